// File: rtl/freq_gen_div.sv
// Programmable 50%-duty square-wave generator driven by an HPS control word {en, inv, div}.
// Optional macro FREQ_GEN_GLITCHFREE_EN defers updates while running to full-period boundaries.
module freq_gen_div #(
  parameter int unsigned DIV_W = 30
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [DIV_W+1:0] ctrl_word,
  output logic             freq_out,
  output logic             rise_pulse,
  output logic [3:0]       status
);

  typedef enum logic {IDLE, RUN} state_e;

  logic             en_q, en_d;
  logic             inv_q, inv_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             pend_q, pend_d;
  logic             freq_q, freq_d;
  logic             rise_q, rise_d;

  state_e st;
  logic   pending;
  logic   half_bnd;
  logic   full_bnd;
  logic   apply;

  assign st       = (en_q && (div_q != '0)) ? RUN : IDLE;
  assign pending  = (ctrl_word != {en_q, inv_q, div_q});
  assign half_bnd = (st == RUN) && (cnt_q == (div_q - DIV_W'(1)));
  assign full_bnd = half_bnd && phase_q;

`ifdef FREQ_GEN_GLITCHFREE_EN
  assign apply = pending && ((st == IDLE) || full_bnd);
`else
  assign apply = pending;
`endif

  always_comb begin
    en_d    = en_q;
    inv_d   = inv_q;
    div_d   = div_q;
    cnt_d   = '0;
    phase_d = 1'b0;
    if (apply) begin
      en_d  = ctrl_word[DIV_W+1];
      inv_d = ctrl_word[DIV_W];
      div_d = ctrl_word[DIV_W-1:0];
    end else if (st == RUN) begin
      if (half_bnd) begin
        phase_d = ~phase_q;
      end else begin
        cnt_d   = cnt_q + DIV_W'(1);
        phase_d = phase_q;
      end
    end
    // Pending is re-evaluated against the post-edge active word so it drops on the apply edge.
    pend_d = (ctrl_word != {en_d, inv_d, div_d});
    freq_d = phase_d ^ inv_d;
    rise_d = phase_d & ~phase_q;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      en_q    <= 1'b0;
      inv_q   <= 1'b0;
      div_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      pend_q  <= 1'b0;
      freq_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      en_q    <= en_d;
      inv_q   <= inv_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      pend_q  <= pend_d;
      freq_q  <= freq_d;
      rise_q  <= rise_d;
    end
  end

  assign freq_out   = freq_q;
  assign rise_pulse = rise_q;
  assign status     = {phase_q, en_q & (div_q == '0), pend_q, st == RUN};

endmodule

// File: tb/tb_freq_gen_div.sv
// Randomized and directed checks of freq_gen_div against an elapsed-time reference model.
module tb_freq_gen_div;

  localparam int unsigned DW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW+1:0] ctrl = '0;
  logic          freq_out;
  logic          rise_pulse;
  logic [3:0]    status;
  logic [5:0]    obs;

  int checks = 0;
  int errors = 0;

  bit          m_en, m_inv, m_ph, m_rise, m_pend, m_run;
  int unsigned m_div, m_e;

  freq_gen_div #(.DIV_W(DW)) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .ctrl_word    (ctrl),
    .freq_out     (freq_out),
    .rise_pulse   (rise_pulse),
    .status       (status)
  );

  always #5 clk = ~clk;

  assign obs = {freq_out, rise_pulse, status};

  function automatic logic [DW+1:0] cw(bit en, bit inv, int unsigned div);
    return {en, inv, DW'(div)};
  endfunction

  function automatic logic [5:0] expv();
    return {m_ph ^ m_inv, m_rise, m_ph, m_en && (m_div == 0), m_pend, m_run};
  endfunction

  task automatic model_reset();
    m_en = 0; m_inv = 0; m_div = 0; m_e = 0;
    m_ph = 0; m_rise = 0; m_pend = 0; m_run = 0;
  endtask

  // The model tracks edges elapsed since the last apply; phase is (elapsed / div) mod 2.
  task automatic tick();
    bit run, bnd, pend, ap, pph;
    @(posedge clk);
    run  = m_en && (m_div != 0);
    bnd  = run && (m_e == 2 * m_div - 1);
    pend = (ctrl != cw(m_en, m_inv, m_div));
`ifdef FREQ_GEN_GLITCHFREE_EN
    ap = pend && (!run || bnd);
`else
    ap = pend;
`endif
    pph = m_ph;
    if (ap) begin
      m_en = ctrl[DW+1]; m_inv = ctrl[DW]; m_div = ctrl[DW-1:0]; m_e = 0;
    end else if (run) begin
      m_e = (m_e + 1) % (2 * m_div);
    end else begin
      m_e = 0;
    end
    m_run  = m_en && (m_div != 0);
    m_ph   = m_run ? (((m_e / m_div) % 2) == 1) : 1'b0;
    m_rise = m_ph && !pph;
    m_pend = (ctrl != cw(m_en, m_inv, m_div));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ctrl  = '0;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ctrl  = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 6'b0) begin
        errors++;
        $display("FAIL reset: cycle %0d got %b expected %b", i, obs, 6'b0);
      end
    end
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL reset_idle: cycle %0d got %b expected %b", i, obs, expv());
      end
    end
  endtask

  task automatic test_div5();
    int highs = 0, rises = 0;
    do_reset();
    ctrl = cw(1, 0, 5);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 0) begin
        checks++;
        if (status[0] !== 1'b1) begin
          errors++;
          $display("FAIL div5_run: got %b expected 1", status[0]);
        end
      end
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL div5: cycle %0d got %b expected %b", i, obs, expv());
      end
      highs += int'(freq_out);
      rises += int'(rise_pulse);
    end
    checks++;
    if (highs != 20 || rises != 4) begin
      errors++;
      $display("FAIL div5_duty: got highs=%0d rises=%0d expected highs=20 rises=4", highs, rises);
    end
  endtask

  task automatic test_div1_inv();
    logic prev;
    do_reset();
    ctrl = cw(1, 1, 1);
    tick();
    checks++;
    if (freq_out !== 1'b1) begin
      errors++;
      $display("FAIL div1_start: got %b expected 1", freq_out);
    end
    prev = freq_out;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (obs !== expv() || freq_out === prev) begin
        errors++;
        $display("FAIL div1: cycle %0d got %b expected %b (prev freq %b)", i, obs, expv(), prev);
      end
      prev = freq_out;
    end
  endtask

  task automatic test_div0();
    do_reset();
    ctrl = cw(1, 1, 0);
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (obs !== expv() || status !== 4'b0100 || freq_out !== 1'b1 || rise_pulse !== 1'b0) begin
        errors++;
        $display("FAIL div0: cycle %0d got %b expected %b", i, obs, expv());
      end
    end
  endtask

  task automatic test_glitchfree();
    int pend_cnt = 0, last_rise = -1, spacing = -1;
    do_reset();
    ctrl = cw(1, 0, 5);
    for (int i = 1; i <= 40; i++) begin
      tick();
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL switch: cycle %0d got %b expected %b", i, obs, expv());
      end
      pend_cnt += int'(status[1]);
      if (rise_pulse && i > 11) begin
        if (last_rise >= 0 && spacing < 0) spacing = i - last_rise;
        last_rise = i;
      end
      if (i == 7) ctrl = cw(1, 0, 3);
    end
`ifdef FREQ_GEN_GLITCHFREE_EN
    checks++;
    if (pend_cnt != 3) begin
      errors++;
      $display("FAIL switch_pending: got %0d cycles expected 3", pend_cnt);
    end
`else
    checks++;
    if (pend_cnt != 0) begin
      errors++;
      $display("FAIL switch_pending: got %0d cycles expected 0", pend_cnt);
    end
`endif
    checks++;
    if (spacing != 6) begin
      errors++;
      $display("FAIL switch_period: got %0d expected 6", spacing);
    end
  endtask

  task automatic test_maxdiv();
    int rises = 0;
    do_reset();
    ctrl = cw(1, 0, (1 << DW) - 1);
    for (int i = 0; i < 260; i++) begin
      tick();
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL maxdiv: cycle %0d got %b expected %b", i, obs, expv());
      end
      rises += int'(rise_pulse);
    end
    checks++;
    if (rises != 2) begin
      errors++;
      $display("FAIL maxdiv_rises: got %0d expected 2", rises);
    end
  endtask

  task automatic test_churn();
    do_reset();
    ctrl = cw(1, 0, 4);
    for (int i = 0; i < 40; i++) begin
      if (i >= 10 && i < 14) ctrl = cw(1, i[0], 2 + i % 3);
      if (i == 14) ctrl = cw(1, 0, 4);
      if (i >= 24 && i < 27) ctrl = cw(1, 1, 7 - (i % 2));
      tick();
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL churn: cycle %0d got %b expected %b", i, obs, expv());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0)
        ctrl = cw($urandom_range(3) != 0, $urandom_range(1) == 1, $urandom_range(7));
      tick();
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL random: cycle %0d ctrl %h got %b expected %b", i, ctrl, obs, expv());
      end
    end
  endtask

  task automatic test_reset_midrun();
    int rises = 0;
    do_reset();
    ctrl = cw(1, 1, 5);
    for (int i = 0; i < 13; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 6'b0) begin
      errors++;
      $display("FAIL async_reset: got %b expected %b", obs, 6'b0);
    end
    model_reset();
    ctrl = cw(1, 0, 4);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (obs !== 6'b0) begin
      errors++;
      $display("FAIL reset_hold: got %b expected %b", obs, 6'b0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL resume: cycle %0d got %b expected %b", i, obs, expv());
      end
      rises += int'(rise_pulse);
    end
    checks++;
    if (rises != 3) begin
      errors++;
      $display("FAIL resume_rises: got %0d expected 3", rises);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_div5();
    test_div1_inv();
    test_div0();
    test_glitchfree();
    test_maxdiv();
    test_churn();
    test_random();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
